tlk2711_rx_frame_buf: RTL and testbench
=======================================

# tlk2711_rx_frame_buf

Parametrised store-and-forward receive buffer for one TLK2711 lane, in the system `clk` domain directly after the rx clock-domain-crossing FIFO. It tracks link synchronisation from idle characters and extracts payload words between start-of-frame and end-of-frame control words. Payload is queued in an internal synchronous FIFO, and a frame is only released downstream once it has been received whole and error-free. Aborted, oversize and overflowing frames are rolled back and counted.

## Interface
- DATAWIDTH, 16, payload word width (multiple of 8).
- DEPTH, 1024, FIFO depth in words (power of 2, ≥ 16).
- MAX_LEN, 512, maximum payload words per frame (≤ DEPTH−1).
- LOCK_CNT, 8, consecutive idle words needed for link up.
- LOS_CNT, 4, consecutive errored words that force link down.
- IDLE_WORD, 16'hC5BC; SOF_WORD, 16'hFBFB; EOF_WORD, 16'hFDFD: control-word codes, compared only when `i_rx_k`=1.

Ports:
- clk  in  1  system clock; only clock.
- rst_n  in  1  synchronous active-low reset.
- i_soft_rst  in  1  synchronous clear, same effect as reset.
- i_rx_data  in  DATAWIDTH  word from CDC FIFO.
- i_rx_k  in  1  word is a control word (OR of byte K flags).
- i_rx_err  in  1  decoder code/disparity error on this word.
- i_rx_valid  in  1  word present; consumed every cycle it is high (no back-pressure).
- o_data  out  DATAWIDTH  payload word.
- o_last  out  1  final word of frame.
- o_valid  out  1  o_data/o_last valid.
- i_ready  in  1  downstream accepts; transfer when o_valid & i_ready.
- o_link_up  out  1  link synchronised.
- o_frame_cnt  out  32  frames committed (saturating).
- o_drop_cnt  out  16  frames aborted (saturating).
- o_err_cnt  out  16  words with i_rx_err (saturating).
- o_level  out  log2(DEPTH)+1  committed words in FIFO.

## Operation
- All actions below apply only on cycles with i_rx_valid=1, except the read side.
- Link FSM: LOS → (LOCK_CNT consecutive IDLE_WORD, any non-idle or error restarts count) → SYNC. In any state other than LOS, LOS_CNT consecutive i_rx_err words → LOS; an in-progress frame is aborted.
- Frame FSM (active only when link up): SYNC: SOF → FRAME; all other words ignored. FRAME: data word (k=0, err=0) written at speculative pointer wr_spec; EOF → commit; SOF, other control word, errored word, length reaching MAX_LEN+1, or FIFO full → abort. After commit → SYNC. After abort → DROP; DROP ignores everything until EOF (→ SYNC) or SOF (→ FRAME, new frame).
- Each stored entry is {last, data}; on EOF the last written entry has its last bit set (kept as a separate 1-entry pending register so last is known at write time).
- Commit: wr_commit ← wr_spec, o_frame_cnt+1. Abort: wr_spec ← wr_commit, o_drop_cnt+1. Zero-length frame (SOF then EOF): discarded, no counter changes.
- Full: wr_spec − rd_ptr = DEPTH. Write that would exceed → abort.
- Read side sees only committed data; o_valid=1 while rd_ptr ≠ wr_commit (via FWFT output register). o_level = wr_commit − rd_ptr (pointers log2(DEPTH)+1 bits, wrap naturally).
- o_err_cnt increments on every valid word with i_rx_err, in any state.
- Commit, abort and read in the same cycle are legal and independent.

## Timing
- Reset/soft reset: FSMs → LOS/SYNC-idle, pointers 0, all outputs 0 (o_valid, o_last, o_data, o_link_up, counters, o_level). Reset mid-frame discards all FIFO contents.
- o_link_up rises the cycle after the LOCK_CNT-th idle is registered; falls the cycle after the LOS_CNT-th error.
- o_frame_cnt/o_level update 1 cycle after EOF accepted; o_valid rises exactly 2 cycles after EOF accepted when FIFO was empty.
- Read: sustained 1 word/cycle with i_ready=1; o_data stable while o_valid & !i_ready.

## Test plan
- Lock: 7 idles then error then 8 idles → o_link_up high only after the 8th in the second run.
- Good frame: SOF, 0x0001..0x0004, EOF, i_ready=1 → 4 words out, o_last on 0x0004, o_frame_cnt=1, o_valid 2 cycles after EOF.
- Abort: SOF, 3 words, error word, EOF, then clean 2-word frame → only 2 words out, o_drop_cnt=1, o_err_cnt=1, o_frame_cnt=1.
- Overflow: DEPTH=16, i_ready=0, frames of 10 then 10 words → first committed (o_level=10), second dropped, o_level still 10.
- Oversize: MAX_LEN=8, 9-word frame → dropped, nothing output; back-to-back SOF in DROP recovers next frame.
- Soft reset mid-frame with 5 committed words → all outputs 0, o_link_up=0, relock required.

Source files
------------

// File: rtl/tlk2711_rx_frame_buf_if.sv
// Receive-side bundle: incoming TLK2711 words from the CDC FIFO plus the outgoing payload stream.
// The slave modport is the frame buffer; the master modport is the link source and downstream sink.
interface tlk2711_rx_frame_buf_if #(
    parameter int unsigned DATAWIDTH = 16
);
    logic [DATAWIDTH-1:0] rx_data;
    logic                 rx_k;
    logic                 rx_err;
    logic                 rx_valid;
    logic [DATAWIDTH-1:0] data;
    logic                 last;
    logic                 valid;
    logic                 ready;

    modport master (
        output rx_data, rx_k, rx_err, rx_valid, ready,
        input  data, last, valid
    );

    modport slave (
        input  rx_data, rx_k, rx_err, rx_valid, ready,
        output data, last, valid
    );
endinterface

// File: rtl/tlk2711_rx_frame_buf.sv
// Store-and-forward receive buffer for one TLK2711 lane: link sync tracking, frame extraction,
// speculative FIFO writes that are committed on a clean EOF or rolled back on abort.
module tlk2711_rx_frame_buf #(
    parameter int unsigned          DATAWIDTH = 16,
    parameter int unsigned          DEPTH     = 1024,
    parameter int unsigned          MAX_LEN   = 512,
    parameter int unsigned          LOCK_CNT  = 8,
    parameter int unsigned          LOS_CNT   = 4,
    parameter logic [DATAWIDTH-1:0] IDLE_WORD = DATAWIDTH'(16'hC5BC),
    parameter logic [DATAWIDTH-1:0] SOF_WORD  = DATAWIDTH'(16'hFBFB),
    parameter logic [DATAWIDTH-1:0] EOF_WORD  = DATAWIDTH'(16'hFDFD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_soft_rst,
    tlk2711_rx_frame_buf_if.slave   bus,
    output logic                    o_link_up,
    output logic [31:0]             o_frame_cnt,
    output logic [15:0]             o_drop_cnt,
    output logic [15:0]             o_err_cnt,
    output logic [$clog2(DEPTH):0]  o_level
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned LKW = $clog2(LOCK_CNT + 1);
    localparam int unsigned LSW = $clog2(LOS_CNT + 1);
    localparam int unsigned LW  = $clog2(MAX_LEN + 2);

    typedef enum logic [1:0] {ST_LOS, ST_SYNC, ST_FRAME, ST_DROP} state_t;

    state_t               state_q, state_d;
    logic [LKW-1:0]       lock_q, lock_d;
    logic [LSW-1:0]       los_q, los_d;
    logic [LW-1:0]        len_q, len_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [DATAWIDTH-1:0] pend_data_q, pend_data_d;
    logic [PW-1:0]        wr_spec_q, wr_spec_d;
    logic [PW-1:0]        wr_commit_q, wr_commit_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        level_q, level_d;
    logic                 out_valid_q, out_last_q;
    logic [DATAWIDTH-1:0] out_data_q;
    logic                 link_q;
    logic [31:0]          frame_cnt_q;
    logic [15:0]          drop_cnt_q, err_cnt_q;

    logic                 clear;
    logic                 is_idle, is_sof, is_eof, full;
    logic                 we, commit, abort;
    logic [DATAWIDTH:0]   wentry;
    logic                 pop, load, avail;
    logic [DATAWIDTH:0]   mem [DEPTH];

    assign clear   = !rst_n || i_soft_rst;
    assign is_idle = bus.rx_k && !bus.rx_err && (bus.rx_data == IDLE_WORD);
    assign is_sof  = bus.rx_k && !bus.rx_err && (bus.rx_data == SOF_WORD);
    assign is_eof  = bus.rx_k && !bus.rx_err && (bus.rx_data == EOF_WORD);
    assign full    = (wr_spec_q - rd_ptr_q) == PW'(DEPTH);

    // Link and frame next-state; the newest data word waits in the pending register so EOF can tag it
    always_comb begin
        state_d      = state_q;
        lock_d       = lock_q;
        los_d        = los_q;
        len_d        = len_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        wr_spec_d    = wr_spec_q;
        wr_commit_d  = wr_commit_q;
        we           = 1'b0;
        wentry       = '0;
        commit       = 1'b0;
        abort        = 1'b0;
        if (bus.rx_valid) begin
            case (state_q)
                ST_LOS: begin
                    if (!is_idle) begin
                        lock_d = '0;
                    end else if (lock_q == LKW'(LOCK_CNT - 1)) begin
                        lock_d  = '0;
                        state_d = ST_SYNC;
                    end else begin
                        lock_d = lock_q + LKW'(1);
                    end
                end
                ST_SYNC, ST_DROP: begin
                    if (is_sof) begin
                        state_d      = ST_FRAME;
                        len_d        = '0;
                        pend_valid_d = 1'b0;
                    end else if (is_eof) begin
                        state_d = ST_SYNC;
                    end
                end
                ST_FRAME: begin
                    if (bus.rx_err || (bus.rx_k && !is_eof)) begin
                        abort = 1'b1;
                    end else if (is_eof) begin
                        if (!pend_valid_q) begin
                            state_d = ST_SYNC;
                        end else if (full) begin
                            abort = 1'b1;
                        end else begin
                            we           = 1'b1;
                            wentry       = {1'b1, pend_data_q};
                            wr_spec_d    = wr_spec_q + PW'(1);
                            wr_commit_d  = wr_spec_q + PW'(1);
                            commit       = 1'b1;
                            pend_valid_d = 1'b0;
                            state_d      = ST_SYNC;
                        end
                    end else if ((len_q == LW'(MAX_LEN)) || (pend_valid_q && full)) begin
                        abort = 1'b1;
                    end else begin
                        if (pend_valid_q) begin
                            we        = 1'b1;
                            wentry    = {1'b0, pend_data_q};
                            wr_spec_d = wr_spec_q + PW'(1);
                        end
                        pend_valid_d = 1'b1;
                        pend_data_d  = bus.rx_data;
                        len_d        = len_q + LW'(1);
                    end
                end
                default: state_d = ST_LOS;
            endcase
            if (abort) begin
                state_d      = ST_DROP;
                wr_spec_d    = wr_commit_q;
                pend_valid_d = 1'b0;
            end
            // Loss of sync overrides everything, including the DROP just chosen above
            if (state_q != ST_LOS) begin
                if (!bus.rx_err) begin
                    los_d = '0;
                end else if (los_q == LSW'(LOS_CNT - 1)) begin
                    los_d        = '0;
                    lock_d       = '0;
                    state_d      = ST_LOS;
                    pend_valid_d = 1'b0;
                    wr_spec_d    = wr_commit_q;
                end else begin
                    los_d = los_q + LSW'(1);
                end
            end
        end
    end

    // Read side: output register always holds the entry at rd_ptr while it is committed
    assign pop      = out_valid_q && bus.ready;
    assign rd_ptr_d = pop ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    assign load     = !out_valid_q || pop;
    assign avail    = rd_ptr_d != wr_commit_q;
    assign level_d  = wr_commit_d - rd_ptr_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_spec_q[AW-1:0]] <= wentry;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q      <= ST_LOS;
            lock_q       <= '0;
            los_q        <= '0;
            len_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            wr_spec_q    <= '0;
            wr_commit_q  <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            link_q       <= 1'b0;
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            lock_q       <= lock_d;
            los_q        <= los_d;
            len_q        <= len_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            wr_spec_q    <= wr_spec_d;
            wr_commit_q  <= wr_commit_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            link_q       <= (state_d != ST_LOS);
            if (load) begin
                out_valid_q <= avail;
                if (avail) begin
                    {out_last_q, out_data_q} <= mem[rd_ptr_d[AW-1:0]];
                end
            end
            if (commit && (frame_cnt_q != '1)) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end
            if (abort && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (bus.rx_valid && bus.rx_err && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign bus.data    = out_data_q;
    assign bus.last    = out_last_q;
    assign bus.valid   = out_valid_q;
    assign o_link_up   = link_q;
    assign o_frame_cnt = frame_cnt_q;
    assign o_drop_cnt  = drop_cnt_q;
    assign o_err_cnt   = err_cnt_q;
    assign o_level     = level_q;
endmodule

// File: tb/tb_tlk2711_rx_frame_buf.sv
// Directed bench: instance a (DEPTH 16, MAX_LEN 12) and instance b (DEPTH 16, MAX_LEN 8)
// share the receive stimulus; each has its own ready and output capture queue.
module tb_tlk2711_rx_frame_buf;
    localparam logic [15:0] IDLE = 16'hC5BC;
    localparam logic [15:0] SOF  = 16'hFBFB;
    localparam logic [15:0] EOF  = 16'hFDFD;

    logic        clk;
    logic        rst_n, soft_rst;
    logic [15:0] rx_data;
    logic        rx_k, rx_err, rx_valid;
    logic        ready_a, ready_b;

    logic        link_a, link_b;
    logic [31:0] fcnt_a, fcnt_b;
    logic [15:0] dcnt_a, dcnt_b, ecnt_a, ecnt_b;
    logic [4:0]  lvl_a, lvl_b;

    int          vectors;
    int          miscompares;
    logic [16:0] q_a[$];
    logic [16:0] q_b[$];

    tlk2711_rx_frame_buf_if #(.DATAWIDTH(16)) bus_a ();
    tlk2711_rx_frame_buf_if #(.DATAWIDTH(16)) bus_b ();

    assign bus_a.rx_data  = rx_data;
    assign bus_a.rx_k     = rx_k;
    assign bus_a.rx_err   = rx_err;
    assign bus_a.rx_valid = rx_valid;
    assign bus_a.ready    = ready_a;
    assign bus_b.rx_data  = rx_data;
    assign bus_b.rx_k     = rx_k;
    assign bus_b.rx_err   = rx_err;
    assign bus_b.rx_valid = rx_valid;
    assign bus_b.ready    = ready_b;

    tlk2711_rx_frame_buf #(.DATAWIDTH(16), .DEPTH(16), .MAX_LEN(12), .LOCK_CNT(8), .LOS_CNT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_soft_rst(soft_rst), .bus(bus_a),
        .o_link_up(link_a), .o_frame_cnt(fcnt_a), .o_drop_cnt(dcnt_a),
        .o_err_cnt(ecnt_a), .o_level(lvl_a)
    );

    tlk2711_rx_frame_buf #(.DATAWIDTH(16), .DEPTH(16), .MAX_LEN(8), .LOCK_CNT(8), .LOS_CNT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_soft_rst(soft_rst), .bus(bus_b),
        .o_link_up(link_b), .o_frame_cnt(fcnt_b), .o_drop_cnt(dcnt_b),
        .o_err_cnt(ecnt_b), .o_level(lvl_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record each transfer mid-cycle; it completes on the following rising edge
    always @(negedge clk) begin
        if (bus_a.valid && ready_a) q_a.push_back({bus_a.last, bus_a.data});
        if (bus_b.valid && ready_b) q_b.push_back({bus_b.last, bus_b.data});
    end

    task automatic send(input logic k, input logic [15:0] d, input logic e);
        rx_k = k; rx_data = d; rx_err = e; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_k = 1'b0; rx_err = 1'b0; rx_data = '0;
    endtask

    task automatic idles(input int n);
        repeat (n) send(1'b1, IDLE, 1'b0);
    endtask

    task automatic data_words(input logic [15:0] base, input int n);
        for (int i = 1; i <= n; i++) send(1'b0, base + 16'(i), 1'b0);
    endtask

    task automatic frame(input logic [15:0] base, input int n);
        send(1'b1, SOF, 1'b0);
        data_words(base, n);
        send(1'b1, EOF, 1'b0);
    endtask

    task automatic drain(input bit sel_b, input int n);
        for (int i = 0; i < 40; i++) begin
            if ((sel_b ? q_b.size() : q_a.size()) >= n) break;
            idles(1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; soft_rst = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
        rx_valid = 1'b0; rx_k = 1'b0; rx_err = 1'b0; rx_data = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (bus_a.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b want 0", bus_a.valid); end
        vectors++; if (bus_a.data !== 16'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0000", bus_a.data); end
        vectors++; if (link_a !== 1'b0) begin miscompares++; $display("FAIL reset_link: got %0b want 0", link_a); end
        vectors++; if ({fcnt_a, dcnt_a, ecnt_a} !== 64'h0) begin miscompares++; $display("FAIL reset_counters: got %h/%h/%h want 0", fcnt_a, dcnt_a, ecnt_a); end
        vectors++; if (lvl_a !== 5'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", lvl_a); end
        rst_n = 1'b1;
    endtask

    task automatic test_lock();
        idles(7);
        vectors++; if (link_a !== 1'b0) begin miscompares++; $display("FAIL lock_7_idles: got %0b want 0", link_a); end
        send(1'b1, IDLE, 1'b1);
        vectors++; if (link_a !== 1'b0) begin miscompares++; $display("FAIL lock_after_err: got %0b want 0", link_a); end
        idles(7);
        vectors++; if (link_a !== 1'b0) begin miscompares++; $display("FAIL lock_restart_7: got %0b want 0", link_a); end
        idles(1);
        vectors++; if (link_a !== 1'b1) begin miscompares++; $display("FAIL lock_8th_idle: got %0b want 1", link_a); end
        vectors++; if (ecnt_a !== 16'd1) begin miscompares++; $display("FAIL lock_err_cnt: got %0d want 1", ecnt_a); end
    endtask

    task automatic test_good_frame();
        q_a.delete();
        ready_a = 1'b1;
        frame(16'h0000, 4);
        vectors++; if (fcnt_a !== 32'd1) begin miscompares++; $display("FAIL good_frame_cnt: got %0d want 1", fcnt_a); end
        vectors++; if (lvl_a !== 5'd4) begin miscompares++; $display("FAIL good_level: got %0d want 4", lvl_a); end
        vectors++; if (bus_a.valid !== 1'b0) begin miscompares++; $display("FAIL good_valid_early: got %0b want 0", bus_a.valid); end
        idles(1);
        vectors++; if (bus_a.valid !== 1'b1) begin miscompares++; $display("FAIL good_valid_2cyc: got %0b want 1", bus_a.valid); end
        vectors++; if (bus_a.data !== 16'h0001) begin miscompares++; $display("FAIL good_first_data: got %h want 0001", bus_a.data); end
        drain(1'b0, 4);
        idles(2);
        vectors++; if (q_a.size() !== 4) begin miscompares++; $display("FAIL good_count: got %0d want 4", q_a.size()); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (q_a[i] !== {(i == 3), 16'(i + 1)}) begin
                miscompares++; $display("FAIL good_word%0d: got %h want %h", i, q_a[i], {(i == 3), 16'(i + 1)});
            end
        end
        vectors++; if (lvl_a !== 5'd0) begin miscompares++; $display("FAIL good_level_drained: got %0d want 0", lvl_a); end
    endtask

    task automatic test_abort();
        q_a.delete();
        send(1'b1, SOF, 1'b0);
        data_words(16'h0010, 3);
        send(1'b0, 16'h0014, 1'b1);
        send(1'b1, EOF, 1'b0);
        idles(1);
        frame(16'h0020, 2);
        drain(1'b0, 2);
        idles(3);
        vectors++; if (q_a.size() !== 2) begin miscompares++; $display("FAIL abort_count: got %0d want 2", q_a.size()); end
        vectors++; if (q_a[0] !== {1'b0, 16'h0021}) begin miscompares++; $display("FAIL abort_word0: got %h want 00021", q_a[0]); end
        vectors++; if (q_a[1] !== {1'b1, 16'h0022}) begin miscompares++; $display("FAIL abort_word1: got %h want 10022", q_a[1]); end
        vectors++; if (dcnt_a !== 16'd1) begin miscompares++; $display("FAIL abort_drop_cnt: got %0d want 1", dcnt_a); end
        vectors++; if (ecnt_a !== 16'd2) begin miscompares++; $display("FAIL abort_err_cnt: got %0d want 2", ecnt_a); end
        vectors++; if (fcnt_a !== 32'd2) begin miscompares++; $display("FAIL abort_frame_cnt: got %0d want 2", fcnt_a); end
    endtask

    task automatic test_overflow();
        q_a.delete();
        ready_a = 1'b0;
        frame(16'h0A00, 10);
        idles(2);
        vectors++; if (lvl_a !== 5'd10) begin miscompares++; $display("FAIL ovf_level_first: got %0d want 10", lvl_a); end
        vectors++; if (bus_a.valid !== 1'b1 || bus_a.data !== 16'h0A01) begin miscompares++; $display("FAIL ovf_head: got v=%0b d=%h want v=1 d=0a01", bus_a.valid, bus_a.data); end
        frame(16'h0B00, 10);
        idles(1);
        vectors++; if (lvl_a !== 5'd10) begin miscompares++; $display("FAIL ovf_level_second: got %0d want 10", lvl_a); end
        vectors++; if (dcnt_a !== 16'd2) begin miscompares++; $display("FAIL ovf_drop_cnt: got %0d want 2", dcnt_a); end
        vectors++; if (fcnt_a !== 32'd3) begin miscompares++; $display("FAIL ovf_frame_cnt: got %0d want 3", fcnt_a); end
        ready_a = 1'b1;
        drain(1'b0, 10);
        idles(2);
        vectors++; if (q_a.size() !== 10) begin miscompares++; $display("FAIL ovf_count: got %0d want 10", q_a.size()); end
        vectors++; if (q_a[0] !== {1'b0, 16'h0A01}) begin miscompares++; $display("FAIL ovf_word0: got %h want 00a01", q_a[0]); end
        vectors++; if (q_a[9] !== {1'b1, 16'h0A0A}) begin miscompares++; $display("FAIL ovf_word9: got %h want 10a0a", q_a[9]); end
        vectors++; if (lvl_a !== 5'd0) begin miscompares++; $display("FAIL ovf_level_drained: got %0d want 0", lvl_a); end
    endtask

    task automatic test_soft_reset();
        ready_a = 1'b0;
        frame(16'h0C00, 5);
        idles(2);
        vectors++; if (lvl_a !== 5'd5) begin miscompares++; $display("FAIL srst_level_before: got %0d want 5", lvl_a); end
        send(1'b1, SOF, 1'b0);
        data_words(16'h0D00, 2);
        soft_rst = 1'b1;
        @(posedge clk); #1;
        soft_rst = 1'b0;
        vectors++; if ({bus_a.valid, bus_a.last, bus_a.data} !== 18'h0) begin miscompares++; $display("FAIL srst_stream: got v=%0b l=%0b d=%h want 0", bus_a.valid, bus_a.last, bus_a.data); end
        vectors++; if (link_a !== 1'b0 || link_b !== 1'b0) begin miscompares++; $display("FAIL srst_link: got %0b/%0b want 0/0", link_a, link_b); end
        vectors++; if ({fcnt_a, dcnt_a, ecnt_a} !== 64'h0) begin miscompares++; $display("FAIL srst_counters: got %h/%h/%h want 0", fcnt_a, dcnt_a, ecnt_a); end
        vectors++; if (lvl_a !== 5'd0) begin miscompares++; $display("FAIL srst_level: got %0d want 0", lvl_a); end
        frame(16'h0E00, 1);
        idles(1);
        vectors++; if (fcnt_a !== 32'd0 || lvl_a !== 5'd0) begin miscompares++; $display("FAIL srst_no_lock_frame: got f=%0d l=%0d want 0/0", fcnt_a, lvl_a); end
        idles(6);
        vectors++; if (link_a !== 1'b0) begin miscompares++; $display("FAIL srst_relock_7: got %0b want 0", link_a); end
        idles(1);
        vectors++; if (link_a !== 1'b1 || link_b !== 1'b1) begin miscompares++; $display("FAIL srst_relock_8: got %0b/%0b want 1/1", link_a, link_b); end
    endtask

    task automatic test_oversize();
        q_b.delete();
        ready_b = 1'b1;
        send(1'b1, SOF, 1'b0);
        data_words(16'h0030, 8);
        vectors++; if (dcnt_b !== 16'd0) begin miscompares++; $display("FAIL over_at_max: got %0d want 0", dcnt_b); end
        send(1'b0, 16'h0039, 1'b0);
        vectors++; if (dcnt_b !== 16'd1) begin miscompares++; $display("FAIL over_drop_cnt: got %0d want 1", dcnt_b); end
        send(1'b1, SOF, 1'b0);
        data_words(16'h0040, 2);
        send(1'b1, EOF, 1'b0);
        drain(1'b1, 2);
        idles(3);
        vectors++; if (q_b.size() !== 2) begin miscompares++; $display("FAIL over_count: got %0d want 2", q_b.size()); end
        vectors++; if (q_b[0] !== {1'b0, 16'h0041}) begin miscompares++; $display("FAIL over_word0: got %h want 00041", q_b[0]); end
        vectors++; if (q_b[1] !== {1'b1, 16'h0042}) begin miscompares++; $display("FAIL over_word1: got %h want 10042", q_b[1]); end
        vectors++; if (fcnt_b !== 32'd1 || dcnt_b !== 16'd1) begin miscompares++; $display("FAIL over_counters: got f=%0d d=%0d want 1/1", fcnt_b, dcnt_b); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_lock();
        test_good_frame();
        test_abort();
        test_overflow();
        test_soft_reset();
        test_oversize();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
